fir_decimator: RTL and testbench

FIR_DECIMATOR -- requirements
Module: fir_decimator

---
 rtl/fir_decimator.sv | 166 ++++++++++++++++
 tb/tb_fir_decimator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator.sv
// -----------------------------------------------------------------------------
// fir_decimator
//
// Decimates an unsigned 18-bit FIR output stream by DECIM. Each kept sample
// is rounded, shifted right by SHIFT and reduced to 8 bits. The result is
// queued in a small output FIFO with valid/ready handshaking.
//
// Pipeline:
//   edge 1 : a sample with in_valid=1 at phase 0 is captured in stage 1
//   edge 2 : stage 2 rounds and shifts it, then writes it into the FIFO
//   out_valid is therefore visible right after the second edge.
//
// Parameters:
//   DECIM  decimation factor (2..16)
//   SHIFT  right shift applied to each kept sample (1..17)
//   DEPTH  FIFO depth in entries (power of two, 2..16)
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   rst        synchronous, active-low reset
//   in_data    18-bit unsigned input sample
//   in_valid   in_data carries a new sample this cycle
//   out_data   FIFO head sample (0 while the FIFO is empty)
//   out_valid  FIFO not empty
//   out_ready  consumer takes out_data when out_valid && out_ready
//   fifo_full  FIFO holds DEPTH entries
//   drop_flag  sticky: a kept sample was lost to a full FIFO
//
// Build option:
//   FIR_DECIMATOR_SAT_EN  defined   -> results above 255 clamp to 255
//                         undefined -> the low 8 bits are kept (wrap)
// -----------------------------------------------------------------------------
module fir_decimator #(
   parameter int DECIM = 4,
   parameter int SHIFT = 10,
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [17:0] in_data,
   input  logic        in_valid,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        fifo_full,
   output logic        drop_flag
);

   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
   localparam logic [18:0]   ROUND      = 19'd1 << (SHIFT - 1);

   // ---------------------------------------------------------------- phase
   logic [PW-1:0] phase_reg, phase_next;
   logic          keep;

   assign keep = in_valid && (phase_reg == '0);

   always_comb begin
      phase_next = phase_reg;
      if (in_valid) begin
         phase_next = (phase_reg == PHASE_LAST) ? '0 : phase_reg + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         phase_reg <= '0;
      end else begin
         phase_reg <= phase_next;
      end
   end

   // -------------------------------------------------------------- stage 1
   logic        s1_valid_reg;
   logic [17:0] s1_data_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid_reg <= 1'b0;
         s1_data_reg  <= '0;
      end else begin
         s1_valid_reg <= keep;
         if (keep) begin
            s1_data_reg <= in_data;
         end
      end
   end

   // -------------------------------------------------------------- stage 2
   // The extra top bit absorbs the rounding carry, so the sum never overflows.
   logic [18:0] sum;
   logic [18:0] r;
   logic [7:0]  reduced;

   assign sum = {1'b0, s1_data_reg} + ROUND;
   assign r   = sum >> SHIFT;

`ifdef FIR_DECIMATOR_SAT_EN
   assign reduced = (r > 19'd255) ? 8'hFF : r[7:0];
`else
   logic unused_hi;
   assign unused_hi = ^r[18:8];
   assign reduced   = r[7:0];
`endif

   // ----------------------------------------------------------------- FIFO
   logic [7:0]    mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg, count_next;
   logic          drop_flag_reg;
   logic          wr_en, rd_en;

   assign out_valid = (count_reg != '0);
   assign fifo_full = (count_reg == COUNT_FULL);
   assign drop_flag = drop_flag_reg;

   // Gating with out_valid gives a defined 0 after reset without having to
   // clear the storage array.
   assign out_data  = out_valid ? mem_reg[rd_ptr_reg] : 8'd0;

   assign rd_en = out_valid && out_ready;
   // A read in the same cycle frees a slot, so a write at full is lossless.
   assign wr_en = s1_valid_reg && (!fifo_full || rd_en);

   always_comb begin
      count_next = count_reg;
      case ({wr_en, rd_en})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_reg[wr_ptr_reg] <= reduced;
      end
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         drop_flag_reg <= 1'b0;
      end else begin
         count_reg <= count_next;
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (rd_en) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         if (s1_valid_reg && fifo_full && !out_ready) begin
            drop_flag_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fir_decimator.sv
// -----------------------------------------------------------------------------
// tb_fir_decimator
//
// Self-checking bench for fir_decimator (DECIM=4, SHIFT=10, DEPTH=4).
// A queue-based reference model tracks the kept-sample count, the two-edge
// path into the FIFO, the FIFO contents and the sticky drop flag. Directed
// scenarios compare against constants. The random scenario compares every
// cycle against the model.
// -----------------------------------------------------------------------------
module tb_fir_decimator;

   localparam int DECIM = 4;
   localparam int SHIFT = 10;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [17:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        fifo_full;
   logic        drop_flag;

   int errors = 0;
   int checks = 0;

   // reference model state
   int q[$];
   bit m_drop = 0;
   int vcount = 0;
   bit pend_v = 0;
   int pend_val = 0;

   fir_decimator #(.DECIM(DECIM), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fifo_full (fifo_full),
      .drop_flag (drop_flag)
   );

   always #5 clk = ~clk;

   function automatic int expect_val(int x);
      int r;
      r = (x + (1 << (SHIFT - 1))) / (1 << SHIFT);
`ifdef FIR_DECIMATOR_SAT_EN
      if (r > 255) return 255;
      return r;
`else
      return r % 256;
`endif
   endfunction

   // Advance the model with the inputs that the coming edge will sample, then
   // take the edge and settle 1 time unit past it.
   task automatic tick();
      if (!rst) begin
         q.delete();
         m_drop = 0;
         vcount = 0;
         pend_v = 0;
      end else begin
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (pend_v) begin
            if (q.size() < DEPTH) q.push_back(pend_val);
            else m_drop = 1;
         end
         pend_v   = in_valid && (vcount % DECIM == 0);
         pend_val = expect_val(int'(in_data));
         if (in_valid) vcount++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_data = 18'($urandom_range(0, 262143));
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full got=%b exp=0", fifo_full); end
      checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL reset_drop_flag got=%b exp=0", drop_flag); end
      $display("test_reset: out_valid=%b out_data=%0d fifo_full=%b drop_flag=%b", out_valid, out_data, fifo_full, drop_flag);
      in_valid = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_streaming();
      bit exp_v;
      int pulses = 0;
      do_reset();
      in_valid = 1'b1; in_data = 18'd1536; out_ready = 1'b1;
      for (int i = 0; i < 4 * DECIM + 2; i++) begin
         tick();
         // first pulse after the second edge, then one every DECIM cycles
         exp_v = (i >= 1) && ((i - 1) % DECIM == 0);
         checks++;
         if (out_valid !== exp_v) begin
            errors++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, out_valid, exp_v);
         end
         if (exp_v) begin
            pulses++;
            checks++;
            if (out_data !== 8'd2) begin
               errors++; $display("FAIL stream_data cyc=%0d got=%0d exp=2", i, out_data);
            end
         end
      end
      $display("test_streaming: %0d pulses of out_data=2", pulses);
      in_valid = 1'b0;
   endtask

   task automatic test_rounding();
      int got[$];
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < DECIM + 8; i++) begin
         in_valid = (i <= DECIM);
         if (i == 0) in_data = 18'd1535;
         else if (i == DECIM) in_data = 18'd1536;
         else in_data = 18'($urandom_range(0, 262143));
         tick();
         if (out_valid) got.push_back(int'(out_data));
      end
      checks++;
      if (got.size() != 2) begin
         errors++; $display("FAIL round_count got=%0d exp=2", got.size());
      end else begin
         checks++; if (got[0] != 1) begin errors++; $display("FAIL round_1535 got=%0d exp=1", got[0]); end
         checks++; if (got[1] != 2) begin errors++; $display("FAIL round_1536 got=%0d exp=2", got[1]); end
         $display("test_rounding: 1535->%0d 1536->%0d", got[0], got[1]);
      end
   endtask

   task automatic test_overflow();
      int exp_o;
      bit seen = 0;
`ifdef FIR_DECIMATOR_SAT_EN
      exp_o = 255;
`else
      exp_o = 0;
`endif
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 18'd262143;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         tick();
         seen = out_valid;
      end
      checks++;
      if (!seen) begin
         errors++; $display("FAIL overflow_timeout got=no out_valid exp=out_valid");
      end else begin
         checks++;
         if (int'(out_data) != exp_o) begin
            errors++; $display("FAIL overflow_data got=%0d exp=%0d", out_data, exp_o);
         end
         $display("test_overflow: 262143 -> %0d", out_data);
      end
   endtask

   task automatic test_backpressure();
      int got[$];
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 6 * DECIM; i++) begin
         in_valid = 1'b1;
         in_data = (i % DECIM == 0) ? 18'(1024 * (i / DECIM + 1)) : 18'($urandom_range(0, 262143));
         tick();
         if (i == 2 * DECIM + 1) begin
            checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL bp_full_at3 got=%b exp=0", fifo_full); end
         end
         if (i == 3 * DECIM + 1) begin
            checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL bp_full_at4 got=%b exp=1", fifo_full); end
            checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL bp_drop_at4 got=%b exp=0", drop_flag); end
         end
         if (i == 4 * DECIM + 1) begin
            checks++; if (drop_flag !== 1'b1) begin errors++; $display("FAIL bp_drop_at5 got=%b exp=1", drop_flag); end
         end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL bp_full_end got=%b exp=1", fifo_full); end
      checks++; if (out_data !== 8'd1) begin errors++; $display("FAIL bp_head_held got=%0d exp=1", out_data); end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) got.push_back(int'(out_data));
         tick();
      end
      checks++;
      if (got.size() != 4) begin
         errors++; $display("FAIL bp_drain_count got=%0d exp=4", got.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] != k + 1) begin errors++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", k, got[k], k + 1); end
         end
      end
      checks++; if (drop_flag !== 1'b1) begin errors++; $display("FAIL bp_drop_sticky got=%b exp=1", drop_flag); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
      $display("test_backpressure: drained %0d entries, drop_flag=%b", got.size(), drop_flag);
   endtask

   task automatic test_mid_reset();
      int got[$];
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 3 * DECIM; i++) begin
         in_valid = 1'b1;
         in_data = (i % DECIM == 0) ? 18'd1024 : 18'($urandom_range(0, 262143));
         tick();
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got=%b exp=1", out_valid); end
      rst = 1'b0; in_valid = 1'b1; in_data = 18'd7168;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL midrst_full got=%b exp=0", fifo_full); end
      rst = 1'b1; in_valid = 1'b1; in_data = 18'd3072; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid) got.push_back(int'(out_data));
      end
      checks++;
      if (got.size() != 1) begin
         errors++; $display("FAIL midrst_count got=%0d exp=1", got.size());
      end else begin
         checks++;
         if (got[0] != 3) begin errors++; $display("FAIL midrst_first got=%0d exp=3", got[0]); end
      end
      $display("test_mid_reset: %0d output(s) after release", got.size());
   endtask

   task automatic test_random();
      int ev;
      int bad = 0;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = ($urandom_range(0, 3) == 0) ? 18'($urandom_range(260000, 262143))
                                                 : 18'($urandom_range(0, 262143));
         out_ready = ($urandom_range(0, 9) < (i < 300 ? 3 : 6));
         tick();
         ev = (q.size() > 0) ? q[0] : 0;
         checks++;
         if (out_valid !== (q.size() > 0)) begin
            errors++; bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, out_valid, q.size() > 0);
         end
         checks++;
         if (int'(out_data) != ev) begin
            errors++; bad++; $display("FAIL rand_data cyc=%0d got=%0d exp=%0d", i, out_data, ev);
         end
         checks++;
         if (fifo_full !== (q.size() == DEPTH)) begin
            errors++; bad++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", i, fifo_full, q.size() == DEPTH);
         end
         checks++;
         if (drop_flag !== m_drop) begin
            errors++; bad++; $display("FAIL rand_drop cyc=%0d got=%b exp=%b", i, drop_flag, m_drop);
         end
      end
      $display("test_random: 600 cycles, %0d mismatching comparisons", bad);
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_rounding();
      test_overflow();
      test_backpressure();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
